// File: rtl/ram_banked.sv
// Banked DATA_W x 2^ADDR_W word RAM with a hardware clear engine.
// After reset, or on clear_i while idle, every word is swept to zero, one word per cycle,
// with busy_o held high. Writes and clear requests are dropped while busy, and reads return 0.
// Build option: define RAM_BANKED_OUT_REG_EN for a registered read port (1-cycle latency).
// Leave it undefined for a combinational read port (0-cycle latency).
module ram_banked #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned BANK_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clear_done_o,
  output logic [DATA_W-1:0] out_o
);

  localparam int unsigned WordW     = ADDR_W - BANK_W;
  localparam int unsigned NumBanks  = 1 << BANK_W;
  localparam int unsigned BankDepth = 1 << WordW;
  // Keep the bank-select vector legal when there is only one bank.
  localparam int unsigned BankSelW  = (BANK_W > 0) ? BANK_W : 1;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BankSelW-1:0] wr_bank, rd_bank;
  logic [WordW-1:0]  wr_word, rd_word;
  logic [NumBanks-1:0] bank_we;
  logic [DATA_W-1:0] bank_rd [NumBanks];
  logic [DATA_W-1:0] rd_data;

  // State register: reset lands in a full clear sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StClear;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: the sweep advances one word per cycle and leaves after the last word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: registered flags plus the shared write port (the sweep or the user).
  always_comb begin
    busy_d  = (state_d == StClear);
    done_d  = (state_q == StClear) && (state_d == StIdle);
    wr_en   = 1'b0;
    wr_addr = address_i;
    wr_data = in_i;
    if (!rst_i) begin
      unique case (state_q)
        StClear: begin
          wr_en   = 1'b1;
          wr_addr = ptr_q;
          wr_data = '0;
        end
        // A clear request takes priority, so the coincident write is dropped.
        StIdle:  wr_en = load_i & ~clear_i;
        default: wr_en = 1'b0;
      endcase
    end
  end

  assign wr_bank = BankSelW'(wr_addr >> WordW);
  assign wr_word = wr_addr[WordW-1:0];
  assign rd_bank = BankSelW'(address_i >> WordW);
  assign rd_word = address_i[WordW-1:0];

  // Bank write-enable decode: only the addressed bank is strobed.
  always_comb begin
    bank_we = '0;
    if (wr_en) bank_we[wr_bank] = 1'b1;
  end

  for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
    logic [DATA_W-1:0] bank_mem [BankDepth];

    // Per-bank storage write.
    always_ff @(posedge clk_i) begin
      if (bank_we[b]) bank_mem[wr_word] <= wr_data;
    end

    assign bank_rd[b] = bank_mem[rd_word];
  end

  assign rd_data      = bank_rd[rd_bank];
  assign busy_o       = busy_q;
  assign clear_done_o = done_q;

`ifdef RAM_BANKED_OUT_REG_EN
  logic [DATA_W-1:0] out_q;

  // Registered read port: a same-edge write is seen one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) out_q <= '0;
    else       out_q <= busy_q ? '0 : rd_data;
  end

  assign out_o = out_q;
`else
  assign out_o = busy_q ? '0 : rd_data;
`endif

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked: directed scenarios plus randomized traffic,
// checked against an array model of the memory contents.
module tb_ram_banked;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter DUT.
  logic        rst, load, clear, busy, done;
  logic [15:0] in_d, out;
  logic [5:0]  addr;

  // Small-parameter DUT (DATA_W=8, ADDR_W=4, BANK_W=1).
  logic        p_rst, p_load, p_clear, p_busy, p_done;
  logic [7:0]  p_in, p_out;
  logic [3:0]  p_addr;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] ref_mem [64];

  ram_banked u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_i        (in_d),
    .load_i      (load),
    .address_i   (addr),
    .clear_i     (clear),
    .busy_o      (busy),
    .clear_done_o(done),
    .out_o       (out)
  );

  ram_banked #(.DATA_W(8), .ADDR_W(4), .BANK_W(1)) u_dut_p (
    .clk_i       (clk),
    .rst_i       (p_rst),
    .in_i        (p_in),
    .load_i      (p_load),
    .address_i   (p_addr),
    .clear_i     (p_clear),
    .busy_o      (p_busy),
    .clear_done_o(p_done),
    .out_o       (p_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    load  = 1'b0;
    clear = 1'b0;
    addr  = a;
`ifdef RAM_BANKED_OUT_REG_EN
    tick;
`endif
    #2;
    d = out;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    addr = a;
    in_d = d;
    load = 1'b1;
    tick;
    load = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic p_rd(input logic [3:0] a, output logic [7:0] d);
    p_load  = 1'b0;
    p_clear = 1'b0;
    p_addr  = a;
`ifdef RAM_BANKED_OUT_REG_EN
    tick;
`endif
    #2;
    d = p_out;
  endtask

  // Ticks until busy drops (bounded), counting the cycles and the done pulses seen.
  task automatic sweep_len(output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (busy === 1'b1 && cycles < 200) begin
      tick;
      cycles++;
      if (done === 1'b1) dones++;
    end
    repeat (2) begin
      tick;
      if (done === 1'b1) dones++;
    end
  endtask

  task automatic zero_model;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic test_reset;
    int c, d;
    logic [15:0] v;
    logic [5:0] pts [3];
    pts[0] = 6'd0; pts[1] = 6'd37; pts[2] = 6'd63;
    rst = 1'b1;
    repeat (3) tick;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++;
    if (out !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", out); else n_pass++;
    rst = 1'b0;
    sweep_len(c, d);
    n_checks++;
    if (c != 64) $display("FAIL reset_sweep_len: got %0d expected 64", c); else n_pass++;
    n_checks++;
    if (d != 1) $display("FAIL reset_done_pulses: got %0d expected 1", d); else n_pass++;
    zero_model();
    for (int i = 0; i < 3; i++) begin
      rd(pts[i], v);
      n_checks++;
      if (v !== 16'h0000) $display("FAIL reset_zero @%h: got %h expected 0000", pts[i], v);
      else n_pass++;
    end
  endtask

  task automatic test_bank_decode;
    logic [15:0] v;
    logic [5:0] pts [6];
    pts[0] = 6'h00; pts[1] = 6'h08; pts[2] = 6'h3F;
    pts[3] = 6'h01; pts[4] = 6'h09; pts[5] = 6'h37;
    wr(6'h00, 16'h1111);
    wr(6'h08, 16'hAAAA);
    wr(6'h3F, 16'h5555);
    for (int i = 0; i < 6; i++) begin
      rd(pts[i], v);
      n_checks++;
      if (v !== ref_mem[pts[i]])
        $display("FAIL bank_decode @%h: got %h expected %h", pts[i], v, ref_mem[pts[i]]);
      else n_pass++;
    end
  endtask

  task automatic test_read_during_write;
    logic [15:0] old_v;
    wr(6'h20, 16'h0F0F);
    old_v = ref_mem[6'h20];
    addr = 6'h20;
    in_d = 16'hC3C3;
    load = 1'b1;
`ifdef RAM_BANKED_OUT_REG_EN
    tick;
    load = 1'b0;
    ref_mem[6'h20] = 16'hC3C3;
    n_checks++;
    if (out !== old_v) $display("FAIL rdw_old: got %h expected %h", out, old_v); else n_pass++;
    tick;
`else
    #2;
    n_checks++;
    if (out !== old_v) $display("FAIL rdw_old: got %h expected %h", out, old_v); else n_pass++;
    tick;
    load = 1'b0;
    ref_mem[6'h20] = 16'hC3C3;
`endif
    n_checks++;
    if (out !== 16'hC3C3) $display("FAIL rdw_new: got %h expected c3c3", out); else n_pass++;
  endtask

  task automatic test_write_blocked;
    int c, d;
    logic [15:0] v;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (4) tick;
    addr = 6'h10;
    in_d = 16'hBEEF;
    load = 1'b1;
    tick;
    load = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL blocked_busy: got %b expected 1", busy); else n_pass++;
    sweep_len(c, d);
    n_checks++;
    if (c != 59) $display("FAIL blocked_sweep_rest: got %0d expected 59", c); else n_pass++;
    n_checks++;
    if (d != 1) $display("FAIL blocked_done_pulses: got %0d expected 1", d); else n_pass++;
    zero_model();
    rd(6'h10, v);
    n_checks++;
    if (v !== 16'h0000) $display("FAIL blocked_write_dropped: got %h expected 0000", v);
    else n_pass++;
    rd(6'h3F, v);
    n_checks++;
    if (v !== 16'h0000) $display("FAIL blocked_clear_3f: got %h expected 0000", v); else n_pass++;
  endtask

  task automatic test_collision;
    int c, d;
    logic [15:0] v;
    wr(6'h05, 16'h1234);
    rd(6'h05, v);
    n_checks++;
    if (v !== 16'h1234) $display("FAIL collision_pre: got %h expected 1234", v); else n_pass++;
    addr  = 6'h05;
    in_d  = 16'hFFFF;
    load  = 1'b1;
    clear = 1'b1;
    tick;
    load  = 1'b0;
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL collision_busy: got %b expected 1", busy); else n_pass++;
    sweep_len(c, d);
    n_checks++;
    if (c != 64) $display("FAIL collision_sweep_len: got %0d expected 64", c); else n_pass++;
    zero_model();
    rd(6'h05, v);
    n_checks++;
    if (v !== 16'h0000) $display("FAIL collision_zero: got %h expected 0000", v); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep;
    int c, d;
    logic [15:0] v;
    for (int i = 0; i < 64; i++) wr(6'(i), 16'($urandom_range(1, 16'hFFFF)));
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (20) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midsweep_busy: got %b expected 1", busy); else n_pass++;
    sweep_len(c, d);
    n_checks++;
    if (c != 64) $display("FAIL midsweep_sweep_len: got %0d expected 64", c); else n_pass++;
    n_checks++;
    if (d != 1) $display("FAIL midsweep_done_pulses: got %0d expected 1", d); else n_pass++;
    zero_model();
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), v);
      n_checks++;
      if (v !== 16'h0000) $display("FAIL midsweep_zero @%0d: got %h expected 0000", i, v);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int op, c;
    logic [5:0]  a;
    logic [15:0] v;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 99);
      a  = 6'($urandom_range(0, 63));
      if (op < 45) begin
        wr(a, 16'($urandom));
      end else if (op < 92) begin
        rd(a, v);
        n_checks++;
        if (v !== ref_mem[a]) $display("FAIL random_read @%h: got %h expected %h", a, v, ref_mem[a]);
        else n_pass++;
      end else begin
        clear = 1'b1;
        tick;
        clear = 1'b0;
        c = 0;
        // Junk writes during the sweep must all be dropped.
        while (busy === 1'b1 && c < 200) begin
          load = 1'($urandom_range(0, 1));
          addr = 6'($urandom_range(0, 63));
          in_d = 16'($urandom);
          tick;
          c++;
        end
        load = 1'b0;
        n_checks++;
        if (c != 64) $display("FAIL random_sweep_len: got %0d expected 64", c); else n_pass++;
        zero_model();
      end
    end
  endtask

  task automatic test_param;
    int c;
    logic [7:0] v;
    repeat (3) tick;
    p_rst = 1'b0;
    c = 0;
    while (p_busy === 1'b1 && c < 100) begin
      tick;
      c++;
    end
    n_checks++;
    if (c != 16) $display("FAIL param_reset_sweep: got %0d expected 16", c); else n_pass++;
    p_addr = 4'hF; p_in = 8'hA5; p_load = 1'b1; tick;
    p_addr = 4'h7; p_in = 8'h5A; tick;
    p_load = 1'b0;
    p_rd(4'hF, v);
    n_checks++;
    if (v !== 8'hA5) $display("FAIL param_read_f: got %h expected a5", v); else n_pass++;
    p_rd(4'h7, v);
    n_checks++;
    if (v !== 8'h5A) $display("FAIL param_read_7: got %h expected 5a", v); else n_pass++;
    p_clear = 1'b1;
    tick;
    p_clear = 1'b0;
    c = 0;
    while (p_busy === 1'b1 && c < 100) begin
      tick;
      c++;
    end
    n_checks++;
    if (c != 16) $display("FAIL param_clear_sweep: got %0d expected 16", c); else n_pass++;
    p_rd(4'hF, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL param_zero_f: got %h expected 00", v); else n_pass++;
    p_rd(4'h7, v);
    n_checks++;
    if (v !== 8'h00) $display("FAIL param_zero_7: got %h expected 00", v); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; clear = 1'b0; addr = '0; in_d = '0;
    p_rst = 1'b1; p_load = 1'b0; p_clear = 1'b0; p_addr = '0; p_in = '0;
    test_reset();
    test_bank_decode();
    test_read_during_write();
    test_write_blocked();
    test_collision();
    test_reset_mid_sweep();
    test_random();
    test_param();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
